game_flow_ctl: RTL and testbench

Top-level game sequencer between the VGA timing chain and the level/hero logic. It owns the current level number, holds the hero in reset while a level loads, detects the hero reaching the goal once per frame, freezes play for a fixed number of frames, then advances the level. After the last level it enters a finished state until the start button is pressed again. It drives the level input of the map ROM, the hero controller reset and freeze, and a status code for the board LEDs.

---
 rtl/game_flow_ctl_pkg.sv | 42 ++++
 rtl/game_flow_ctl_if.sv | 32 +++
 rtl/game_flow_ctl_edge_sync.sv | 55 +++++
 rtl/game_flow_ctl.sv | 196 +++++++++++++++++++
 tb/tb_game_flow_ctl.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_ctl_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game sequencer: the FSM state enum (whose
// encoding doubles as the LED state code), default goal/hero geometry,
// the level-number width, and the strict-overlap helper used by the goal
// hit detector.
// ----------------------------------------------------------------------------
package game_pkg;

    localparam int LEVEL_W    = 4;

    localparam int GOAL_X_DEF = 481;
    localparam int GOAL_Y_DEF = 108;
    localparam int GOAL_W_DEF = 32;
    localparam int GOAL_H_DEF = 32;
    localparam int HERO_W_DEF = 32;
    localparam int HERO_H_DEF = 32;

    // The numeric value of each state is the code shown on the board LEDs.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_HOLD = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic logic [2:0] state_code_of(state_t s);
        return 3'(s);
    endfunction

    // Strict one-axis overlap of a span [pos, pos+pos_len) against
    // [obj_lo, obj_lo+obj_len). Done 13 bits wide so pos+pos_len cannot wrap.
    function automatic logic span_overlap(logic [11:0] pos, int obj_lo,
                                          int obj_len, int pos_len);
        logic [12:0] p;
        p = {1'b0, pos};
        return (p < 13'(obj_lo + obj_len)) && ((p + 13'(pos_len)) > 13'(obj_lo));
    endfunction

endpackage

// File: rtl/game_flow_ctl_if.sv
// ----------------------------------------------------------------------------
// game_flow_ctl_if
// Bundles the sequencer's connections to the VGA timing chain, the board
// button, the hero position, the map ROM level select and the LED status.
//   master : the sequencer (takes vsync/button/hero position, drives level,
//            hero_rst, freeze, level_done, state_code, timeout)
//   slave  : the surrounding system (opposite directions)
// ----------------------------------------------------------------------------
interface game_flow_ctl_if;

    logic                         vsync_in;
    logic                         btn_start;
    logic [11:0]                  hero_x_pos;
    logic [11:0]                  hero_y_pos;
    logic [game_pkg::LEVEL_W-1:0] level;
    logic                         hero_rst;
    logic                         freeze;
    logic                         level_done;
    logic [2:0]                   state_code;
    logic                         timeout;

    modport master (
        input  vsync_in, btn_start, hero_x_pos, hero_y_pos,
        output level, hero_rst, freeze, level_done, state_code, timeout
    );

    modport slave (
        output vsync_in, btn_start, hero_x_pos, hero_y_pos,
        input  level, hero_rst, freeze, level_done, state_code, timeout
    );

endinterface

// File: rtl/game_flow_ctl_edge_sync.sv
// ----------------------------------------------------------------------------
// edge_sync
// Optional 2-FF synchronizer followed by a registered rising-edge detector.
//   clk, rst : clock, asynchronous active-high reset
//   din      : level input (asynchronous when SYNC_EN=1)
//   pulse    : one-clock registered pulse on each rising edge of din
// With SYNC_EN=1 the pulse appears 3 clocks after din rises; with SYNC_EN=0
// (input already in the clk domain) it appears 1 clock after.
// ----------------------------------------------------------------------------
module edge_sync #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic synced;
    logic prev;

    generate
        if (SYNC_EN) begin : g_sync
            logic s1;
            logic s2;

            // Two flops to settle metastability before the edge detector.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1 <= 1'b0;
                    s2 <= 1'b0;
                end else begin
                    s1 <= din;
                    s2 <= s1;
                end
            end

            assign synced = s2;
        end else begin : g_bypass
            assign synced = din;
        end
    endgenerate

    // Registered edge detect against the previous sampled level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= synced;
            pulse <= synced & ~prev;
        end
    end

endmodule

// File: rtl/game_flow_ctl.sv
// ----------------------------------------------------------------------------
// game_flow_ctl
// Game sequencer: owns the level number, holds the hero in reset while a
// level loads, detects the hero reaching the goal once per frame, freezes
// play for HOLD_FRAMES frames, then advances; after the last level it waits
// in DONE until start is pressed again.
// Ports:
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : game_flow_ctl_if.master (vsync_in, btn_start, hero_x_pos,
//              hero_y_pos in; level, hero_rst, freeze, level_done,
//              state_code, timeout out; all outputs registered)
// Build option GAME_FLOW_TIMEOUT_EN: adds a per-level frame timer that
// restarts the current level after TIME_FRAMES frames in PLAY and pulses
// timeout. Without it timeout is tied low.
// ----------------------------------------------------------------------------
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int LEVELS      = 4,
    parameter int GOAL_X      = GOAL_X_DEF,
    parameter int GOAL_Y      = GOAL_Y_DEF,
    parameter int GOAL_W      = GOAL_W_DEF,
    parameter int GOAL_H      = GOAL_H_DEF,
    parameter int HERO_W      = HERO_W_DEF,
    parameter int HERO_H      = HERO_H_DEF,
    parameter int LOAD_CYCLES = 4,
    parameter int HOLD_FRAMES = 60
`ifdef GAME_FLOW_TIMEOUT_EN
    ,
    parameter int TIME_FRAMES = 3600
`endif
) (
    input logic              clk,
    input logic              rst,
    game_flow_ctl_if.master  bus
);

    state_t               state;
    state_t               state_nxt;
    logic                 start_p;
    logic                 frame_tick;
    logic                 hit;
    logic [15:0]          cnt;
    logic [LEVEL_W-1:0]   level_q;
    logic [LEVEL_W-1:0]   level_nxt;
    logic                 done_nxt;

    edge_sync #(.SYNC_EN(1'b1)) u_start_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.btn_start),
        .pulse (start_p)
    );

    // vsync is already in the pixel clock domain.
    edge_sync #(.SYNC_EN(1'b0)) u_vsync_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.vsync_in),
        .pulse (frame_tick)
    );

    assign hit = span_overlap(bus.hero_x_pos, GOAL_X, GOAL_W, HERO_W) &&
                 span_overlap(bus.hero_y_pos, GOAL_Y, GOAL_H, HERO_H);

`ifdef GAME_FLOW_TIMEOUT_EN
    logic [11:0] timer;
    logic        time_up;
    logic        timeout_nxt;

    assign time_up = frame_tick && (timer == 12'(TIME_FRAMES - 1));

    // Frames spent in PLAY for the current attempt; any state change clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else if (state == ST_PLAY && frame_tick) begin
            timer <= timer + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= timeout_nxt;
        end
    end
`else
    assign bus.timeout = 1'b0;
`endif

    // Next state, level and completion pulse. A goal hit takes priority over
    // timer expiry on the same frame tick.
    always_comb begin
        state_nxt = state;
        level_nxt = level_q;
        done_nxt  = 1'b0;
`ifdef GAME_FLOW_TIMEOUT_EN
        timeout_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start_p) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt == 16'(LOAD_CYCLES - 1)) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (frame_tick && hit) begin
                    state_nxt = ST_HOLD;
                    done_nxt  = 1'b1;
                end
`ifdef GAME_FLOW_TIMEOUT_EN
                else if (time_up) begin
                    state_nxt   = ST_LOAD;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (frame_tick && cnt == 16'(HOLD_FRAMES - 1)) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (level_q == LEVEL_W'(LEVELS - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    level_nxt = level_q + LEVEL_W'(1);
                    state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (start_p) begin
                    state_nxt = ST_IDLE;
                    level_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                level_nxt = '0;
            end
        endcase
    end

    // State and level registers; level moves on the same edge NEXT is left,
    // so map_rom sees the new level for the whole LOAD period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            level_q <= '0;
        end else begin
            state   <= state_nxt;
            level_q <= level_nxt;
        end
    end

    // Shared counter: clocks in LOAD, frame ticks in HOLD; cleared on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == ST_LOAD) begin
            cnt <= cnt + 16'd1;
        end else if (state == ST_HOLD && frame_tick) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Registered decode of the current state onto the hero and LED outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.hero_rst   <= 1'b1;
            bus.freeze     <= 1'b1;
            bus.state_code <= 3'd0;
            bus.level_done <= 1'b0;
        end else begin
            bus.hero_rst   <= (state == ST_IDLE) || (state == ST_LOAD) ||
                              (state == ST_NEXT);
            bus.freeze     <= (state != ST_PLAY);
            bus.state_code <= state_code_of(state);
            bus.level_done <= done_nxt;
        end
    end

    assign bus.level = level_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// ----------------------------------------------------------------------------
// tb_game_flow_ctl
// Self-checking bench for game_flow_ctl: reset values, start latency, goal
// geometry table, level progression to DONE, restart, reset during HOLD,
// optional level timeout (GAME_FLOW_TIMEOUT_EN), then randomized frames
// checked against a frame-level behavioural model of the game rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_flow_ctl;

    localparam int T_LEVELS = 4;
    localparam int T_LOAD   = 4;
    localparam int T_HOLD   = 60;
`ifdef GAME_FLOW_TIMEOUT_EN
    localparam bit T_TO_EN  = 1'b1;
    localparam int T_TIME   = 5;
`else
    localparam bit T_TO_EN  = 1'b0;
    localparam int T_TIME   = 0;
`endif
    localparam int GX = 481;
    localparam int GY = 108;
    localparam int GW = 32;
    localparam int GH = 32;
    localparam int HW = 32;
    localparam int HH = 32;

    logic clk;
    logic rst;

    game_flow_ctl_if bus();

    game_flow_ctl #(
        .LEVELS      (T_LEVELS),
        .GOAL_X      (GX),
        .GOAL_Y      (GY),
        .GOAL_W      (GW),
        .GOAL_H      (GH),
        .HERO_W      (HW),
        .HERO_H      (HH),
        .LOAD_CYCLES (T_LOAD),
        .HOLD_FRAMES (T_HOLD)
`ifdef GAME_FLOW_TIMEOUT_EN
        ,
        .TIME_FRAMES (T_TIME)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: game phase observed at the end of each frame.
    typedef enum {M_IDLE, M_PLAY, M_HOLD, M_DONE} phase_t;
    phase_t m_phase = M_IDLE;
    int m_level = 0;
    int m_hold_left = 0;
    int m_play_frames = 0;
    int m_done = 0;
    int m_timeouts = 0;

    int checks = 0;
    int passed = 0;
    int done_seen = 0;
    int timeout_seen = 0;
    int hrst_rises = 0;
    logic hrst_prev = 1'b1;
    int probe_code = 0;

    typedef struct {
        int x;
        int y;
        bit hit;
    } vec_t;
    vec_t vecs[10];

    // Count output pulses and hero_rst rising edges away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.level_done) done_seen++;
            if (bus.timeout) timeout_seen++;
            if (bus.hero_rst && !hrst_prev) hrst_rises++;
        end
        hrst_prev = bus.hero_rst;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelHit(input int x, input int y);
        return (x < GX + GW) && (x + HW > GX) && (y < GY + GH) && (y + HH > GY);
    endfunction

    function automatic int modelCode(input phase_t p);
        case (p)
            M_IDLE:  return 0;
            M_PLAY:  return 2;
            M_HOLD:  return 3;
            default: return 5;
        endcase
    endfunction

    task automatic modelFrame(input int x, input int y);
        case (m_phase)
            M_PLAY: begin
                if (modelHit(x, y)) begin
                    m_phase = M_HOLD;
                    m_hold_left = T_HOLD;
                    m_done++;
                end else begin
                    m_play_frames++;
                    if (T_TO_EN && m_play_frames == T_TIME) begin
                        m_timeouts++;
                        m_play_frames = 0;
                    end
                end
            end
            M_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    if (m_level == T_LEVELS - 1) begin
                        m_phase = M_DONE;
                    end else begin
                        m_level++;
                        m_phase = M_PLAY;
                        m_play_frames = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic modelStart();
        if (m_phase == M_IDLE) begin
            m_phase = M_PLAY;
            m_level = 0;
            m_play_frames = 0;
        end else if (m_phase == M_DONE) begin
            m_phase = M_IDLE;
            m_level = 0;
        end
    endtask

    task automatic checkModel();
        checkOutput("level", int'(bus.level), m_level);
        checkOutput("state_code", int'(bus.state_code), modelCode(m_phase));
        checkOutput("freeze", int'(bus.freeze), (m_phase == M_PLAY) ? 0 : 1);
        if (m_phase == M_IDLE || m_phase == M_PLAY)
            checkOutput("hero_rst", int'(bus.hero_rst), (m_phase == M_IDLE) ? 1 : 0);
        checkOutput("level_done_count", done_seen, m_done);
        checkOutput("timeout_count", timeout_seen, m_timeouts);
    endtask

    // One 16-clock frame with the hero held at (x,y); vsync high 3 clocks.
    task automatic applyStimulus(input int x, input int y);
        @(negedge clk);
        bus.hero_x_pos = 12'(x);
        bus.hero_y_pos = 12'(y);
        bus.vsync_in   = 1'b1;
        repeat (3) @(negedge clk);
        probe_code = int'(bus.state_code);
        bus.vsync_in = 1'b0;
        repeat (13) @(negedge clk);
        modelFrame(x, y);
    endtask

    task automatic pressStart();
        @(negedge clk);
        bus.btn_start = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_start = 1'b0;
        repeat (14) @(negedge clk);
        modelStart();
    endtask

    task automatic ensurePlay();
        for (int g = 0; g < 200 && m_phase != M_PLAY; g++) begin
            if (m_phase == M_IDLE || m_phase == M_DONE) pressStart();
            else applyStimulus(0, 0);
            checkModel();
        end
    endtask

    task automatic hitAndHold();
        applyStimulus(GX, GY);
        checkModel();
        for (int i = 0; i < T_HOLD; i++) begin
            applyStimulus(0, 0);
            checkModel();
        end
    endtask

    initial begin
        int d0;
        int t0;
        int h0;

        vecs[0] = '{481, 108, 1'b1};
        vecs[1] = '{449, 108, 1'b0};
        vecs[2] = '{450, 108, 1'b1};
        vecs[3] = '{513, 108, 1'b0};
        vecs[4] = '{512, 108, 1'b1};
        vecs[5] = '{481,  76, 1'b0};
        vecs[6] = '{481,  77, 1'b1};
        vecs[7] = '{481, 140, 1'b0};
        vecs[8] = '{481, 139, 1'b1};
        vecs[9] = '{  0,   0, 1'b0};

        bus.vsync_in   = 1'b0;
        bus.btn_start  = 1'b0;
        bus.hero_x_pos = 12'd0;
        bus.hero_y_pos = 12'd0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        checkOutput("rst_level", int'(bus.level), 0);
        checkOutput("rst_hero_rst", int'(bus.hero_rst), 1);
        checkOutput("rst_freeze", int'(bus.freeze), 1);
        checkOutput("rst_state_code", int'(bus.state_code), 0);
        checkOutput("rst_level_done", int'(bus.level_done), 0);
        checkOutput("rst_timeout", int'(bus.timeout), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkModel();

        // Start latency: 3 clocks to start_p, +1 state, +1 outputs; LOAD 4 clocks.
        bus.btn_start = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("start_still_idle", int'(bus.state_code), 0);
        bus.btn_start = 1'b0;
        for (int i = 0; i < T_LOAD; i++) begin
            @(negedge clk);
            checkOutput("load_code", int'(bus.state_code), 1);
            checkOutput("load_hero_rst", int'(bus.hero_rst), 1);
            checkOutput("load_level", int'(bus.level), 0);
        end
        @(negedge clk);
        checkOutput("play_code", int'(bus.state_code), 2);
        checkOutput("play_freeze", int'(bus.freeze), 0);
        checkOutput("play_hero_rst", int'(bus.hero_rst), 0);
        m_phase = M_PLAY;
        m_level = 0;
        m_play_frames = 0;
        repeat (4) @(negedge clk);

        // Hero exactly on the goal: one level_done, HOLD_FRAMES frozen, level 1.
        d0 = done_seen;
        h0 = hrst_rises;
        applyStimulus(GX, GY);
        checkOutput("hit_done_pulse", done_seen - d0, 1);
        checkOutput("hit_freeze", int'(bus.freeze), 1);
        for (int i = 0; i < T_HOLD - 1; i++) begin
            applyStimulus(0, 0);
            checkOutput("hold_freeze", int'(bus.freeze), 1);
        end
        checkOutput("hold_code_last", int'(bus.state_code), 3);
        checkOutput("hold_level_last", int'(bus.level), 0);
        applyStimulus(0, 0);
        checkOutput("next_level", int'(bus.level), 1);
        checkOutput("next_code", int'(bus.state_code), 2);
        checkOutput("next_hero_rst_pulse", hrst_rises - h0, 1);
        checkModel();

        // Edges touching only: never a hit.
        d0 = done_seen;
        for (int i = 0; i < 10; i++) applyStimulus(449, 108);
        checkOutput("touch_no_done", done_seen - d0, 0);
        checkOutput("touch_code", int'(bus.state_code), 2);
        checkModel();

        // Finish levels 1..3, land in DONE, restart back to IDLE.
        for (int k = 0; k < 3; k++) hitAndHold();
        checkOutput("done_code", int'(bus.state_code), 5);
        checkOutput("done_level", int'(bus.level), T_LEVELS - 1);
        checkOutput("done_freeze", int'(bus.freeze), 1);
        pressStart();
        checkOutput("restart_code", int'(bus.state_code), 0);
        checkOutput("restart_level", int'(bus.level), 0);
        checkModel();

`ifdef GAME_FLOW_TIMEOUT_EN
        // Timer expiry restarts the level; a hit on the expiry frame wins.
        pressStart();
        checkModel();
        t0 = timeout_seen;
        for (int i = 0; i < T_TIME - 1; i++) applyStimulus(0, 0);
        checkOutput("to_not_yet", timeout_seen - t0, 0);
        applyStimulus(0, 0);
        checkOutput("to_probe_load", probe_code, 1);
        checkOutput("to_pulse", timeout_seen - t0, 1);
        checkOutput("to_same_level", int'(bus.level), 0);
        checkModel();
        t0 = timeout_seen;
        d0 = done_seen;
        for (int i = 0; i < T_TIME - 1; i++) applyStimulus(0, 0);
        applyStimulus(GX, GY);
        checkOutput("to_hit_probe", probe_code, 3);
        checkOutput("to_hit_done", done_seen - d0, 1);
        checkOutput("to_hit_no_timeout", timeout_seen - t0, 0);
        checkModel();
`else
        t0 = timeout_seen;
        for (int i = 0; i < 8; i++) applyStimulus(0, 0);
        checkOutput("no_timeout_build", timeout_seen - t0, 0);
`endif

        // Goal geometry table, one frame per vector from PLAY.
        foreach (vecs[i]) begin
            ensurePlay();
            d0 = done_seen;
            applyStimulus(vecs[i].x, vecs[i].y);
            checkOutput("vec_code", int'(bus.state_code), vecs[i].hit ? 3 : 2);
            checkOutput("vec_done", done_seen - d0, vecs[i].hit ? 1 : 0);
            checkModel();
        end

        // Reset during HOLD; start presses in HOLD are ignored.
        ensurePlay();
        applyStimulus(GX, GY);
        checkModel();
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        pressStart();
        checkOutput("hold_ignores_start", int'(bus.state_code), 3);
        checkModel();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_level", int'(bus.level), 0);
        checkOutput("async_rst_hero_rst", int'(bus.hero_rst), 1);
        checkOutput("async_rst_freeze", int'(bus.freeze), 1);
        checkOutput("async_rst_code", int'(bus.state_code), 0);
        checkOutput("async_rst_done", int'(bus.level_done), 0);
        checkOutput("async_rst_timeout", int'(bus.timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        m_phase = M_IDLE;
        m_level = 0;
        m_play_frames = 0;
        repeat (4) @(negedge clk);
        checkModel();

        // Randomized frames and start presses against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if ((m_phase == M_IDLE || m_phase == M_DONE) ? (r < 5) : (r == 0)) begin
                pressStart();
            end else begin
                applyStimulus(400 + int'($urandom_range(0, 160)),
                              40 + int'($urandom_range(0, 140)));
            end
            checkModel();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
